// File: rtl/tlul_pkg.sv
// Shared TL-UL constants, field widths and the response record carried by the
// D-channel queue.
package tlul_pkg;

  localparam int TL_AW   = 32;
  localparam int TL_DW   = 64;
  localparam int TL_MW   = TL_DW / 8;
  localparam int TL_SZW  = 3;
  localparam int TL_SRCW = 4;
  localparam int TL_OPW  = 3;

  typedef enum logic [TL_OPW-1:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [TL_OPW-1:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    logic [TL_OPW-1:0]  opcode;
    logic [TL_SZW-1:0]  size;
    logic [TL_SRCW-1:0] source;
    logic               denied;
    logic [TL_DW-1:0]   data;
    logic               corrupt;
  } tl_d_rsp_t;

  // Low address bits that must be zero for a transfer of 2^size bytes.
  function automatic logic [2:0] size_align_mask(input logic [TL_SZW-1:0] size);
    logic [2:0] m;
    case (size)
      3'd0:    m = 3'b000;
      3'd1:    m = 3'b001;
      3'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlul_resp_fifo.sv
// Two-entry response queue; the head entry is a register that drives the
// D channel directly.
module tlul_resp_fifo
  import tlul_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  tl_d_rsp_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output tl_d_rsp_t head
);

  tl_d_rsp_t   head_q;
  tl_d_rsp_t   tail_q;
  logic [1:0]  count_q;
  logic        wr;
  logic        rd;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign head  = head_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({wr, rd})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Simultaneous push and pop only happens with one entry held.
        2'b11: head_q <= push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tlul_mem_responder.sv
// TL-UL device answering Get/Put accesses to a small 64-bit word memory
// mapped at BASE_ADDR, with a two-deep registered response queue.
module tlul_mem_responder
  import tlul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
  parameter int          DEPTH     = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [3:0]  a_source,
  input  logic [31:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic        d_denied,
  output logic [63:0] d_data,
  output logic        d_corrupt
);

  localparam int IDXW = $clog2(DEPTH);

  logic [TL_DW-1:0] mem_q [DEPTH];
  logic [IDXW-1:0]  word_idx;
  logic             a_fire;
  logic             in_window;
  logic             aligned;
  logic             op_ok;
  logic             legal;
  logic             is_get;
  logic             fifo_full;
  logic             fifo_empty;
  tl_d_rsp_t        rsp;
  tl_d_rsp_t        head;
  logic             unused_a_param;

  assign unused_a_param = ^a_param;

  assign a_ready   = !fifo_full;
  assign a_fire    = a_valid && a_ready;
  assign word_idx  = a_address[IDXW+2:3];
  assign in_window = (a_address[31:7] == BASE_ADDR[31:7]);
  assign aligned   = ((a_address[2:0] & size_align_mask(a_size)) == 3'b000);
  assign op_ok     = (a_opcode == PUT_FULL_DATA) || (a_opcode == PUT_PARTIAL_DATA) ||
                     (a_opcode == GET);
  assign legal     = in_window && (a_size <= 3'd3) && aligned && op_ok;
  assign is_get    = (a_opcode == GET);

  // Response is captured at acceptance, so later Puts cannot change queued data.
  always_comb begin
    rsp        = '0;
    rsp.size   = a_size;
    rsp.source = a_source;
    rsp.denied = !legal;
    if (is_get) begin
      rsp.opcode  = ACCESS_ACK_DATA;
      rsp.data    = legal ? mem_q[word_idx] : '0;
      rsp.corrupt = !legal;
    end else begin
      rsp.opcode  = ACCESS_ACK;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else if (a_fire && legal && !is_get) begin
      for (int b = 0; b < TL_MW; b++) begin
        if (a_mask[b]) mem_q[word_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  tlul_resp_fifo u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (a_fire),
    .push_data (rsp),
    .pop       (d_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign d_valid   = !fifo_empty;
  assign d_opcode  = head.opcode;
  assign d_param   = 2'b00;
  assign d_size    = head.size;
  assign d_source  = head.source;
  assign d_denied  = head.denied;
  assign d_data    = head.data;
  assign d_corrupt = head.corrupt;

endmodule
